mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Load/store access stage: runs one single-beat transaction on the data bus per
// aligned request, stalls the pipeline while it is outstanding, returns aligned loads.
module mem_access_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] O_outEXMEM,
  input  logic [31:0] o_RT_DataEXMEM,
  input  logic        re_inEXMEM,
  input  logic        we_inEXMEM,
  input  logic [1:0]  size_inEXMEM,
  input  logic        lbsigned_outEXMEM,
  input  logic        lbunsigned_outEXMEM,
  input  logic        lhsigned_outEXMEM,
  input  logic        lhunsigned_outEXMEM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [7:0]        wdogCnt;
  logic [1:0]        accSize_p1;
  logic [1:0]        accOff_p1;
  logic              accLoad_p1;
  logic              accSext_p1;
  logic              reqAny;
  logic              aligned;
  logic              sextReq;
  logic              startAcc;
  logic              misalign;
  logic              stallComb;
  logic              timeout;

  // Big-endian lane extraction: offset 0 is the most significant byte.
  function automatic logic [DATA_W-1:0] alignLoad(input logic [DATA_W-1:0] rdata,
                                                  input logic [1:0] size,
                                                  input logic [1:0] off,
                                                  input logic sext);
    logic signed [7:0]        laneB;
    logic signed [15:0]       laneH;
    logic signed [DATA_W-1:0] wide;
    case (off)
      2'd0:    laneB = $signed(rdata[31:24]);
      2'd1:    laneB = $signed(rdata[23:16]);
      2'd2:    laneB = $signed(rdata[15:8]);
      default: laneB = $signed(rdata[7:0]);
    endcase
    laneH = $signed(off[1] ? rdata[15:0] : rdata[31:16]);
    wide  = $signed(rdata);
    if (size == 2'b00) begin
      wide = sext ? 32'(laneB) : $signed({24'h0, laneB});
    end else if (size == 2'b01) begin
      wide = sext ? 32'(laneH) : $signed({16'h0, laneH});
    end
    return $unsigned(wide);
  endfunction

  function automatic logic [DATA_W-1:0] storeLanes(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] rt);
    case (size)
      2'b00:   return {4{rt[7:0]}};
      2'b01:   return {2{rt[15:0]}};
      default: return rt;
    endcase
  endfunction

  function automatic logic [3:0] byteEnables(input logic [1:0] size,
                                             input logic [1:0] off);
    case (size)
      2'b00:   return 4'b1000 >> off;
      2'b01:   return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  assign reqAny = re_inEXMEM | we_inEXMEM;

  always_comb begin
    aligned = 1'b1;
    sextReq = 1'b0;
    case (size_inEXMEM)
      2'b00: sextReq = lbsigned_outEXMEM & ~lbunsigned_outEXMEM;
      2'b01: begin
        aligned = ~O_outEXMEM[0];
        sextReq = lhsigned_outEXMEM & ~lhunsigned_outEXMEM;
      end
      default: aligned = (O_outEXMEM[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    nextState = state;
    startAcc  = 1'b0;
    misalign  = 1'b0;
    stallComb = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (reqAny) begin
          if (aligned) begin
            startAcc  = 1'b1;
            stallComb = 1'b1;
            nextState = S_WAIT;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stallComb = 1'b1;
        if (bus_ack) begin
          nextState = S_DONE;
        end else if (wdogCnt == 8'hFF) begin
          timeout   = 1'b1;
          nextState = S_DONE;
        end
      end
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Combinational pulses are masked while reset is held so they read 0 immediately.
  assign bus_req      = (state == S_WAIT);
  assign mem_stall    = reset & stallComb;
  assign misalign_exc = reset & misalign;
  assign bus_err      = reset & timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Stage p1: bus cycle launched from the EX/MEM request, held until completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      load_data <= '0;
      wdogCnt   <= '0;
    end else begin
      if (startAcc) begin
        bus_we    <= we_inEXMEM;
        bus_addr  <= {O_outEXMEM[31:2], 2'b00};
        bus_wdata <= storeLanes(size_inEXMEM, o_RT_DataEXMEM);
        bus_be    <= byteEnables(size_inEXMEM, O_outEXMEM[1:0]);
        wdogCnt   <= '0;
      end else if (state == S_WAIT) begin
        wdogCnt <= wdogCnt + 8'd1;
      end
      if ((state == S_WAIT) && bus_ack && accLoad_p1) begin
        load_data <= alignLoad(bus_rdata, accSize_p1, accOff_p1, accSext_p1);
      end else if (timeout) begin
        load_data <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (startAcc) begin
      accSize_p1 <= size_inEXMEM;
      accOff_p1  <= O_outEXMEM[1:0];
      accLoad_p1 <= ~we_inEXMEM;
      accSext_p1 <= sextReq;
    end
  end

endmodule
